// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte (start, 8 data bits LSB first, odd parity, stop) to
// the keyboard. The host drives the lines only by pulling them low through
// the *_oe outputs; the device supplies the clock and the final ACK bit.
module ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_err
);

  // One counter serves both the inhibit phase and the device-edge timeout.
  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);
  localparam logic [FLT_W-1:0] FLT_ZERO = {FLT_W{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQ       = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_t;

  // Odd parity: the bit that makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Index 0 carries the PS2_CLK path, index 1 the PS2_DAT path.
  logic [1:0]            sync1_r, sync2_r;
  logic [1:0]            filt_r, filt_s;
  logic [1:0][FLT_W-1:0] fcnt_r, fcnt_s;
  logic                  clk_prev_r;
  logic                  fall_s;

  state_t       state_r, state_s;
  logic [9:0]   frame_r, frame_s;
  logic [3:0]   bitcnt_r, bitcnt_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic         done_s, err_s, timeout_s;

  logic ps2_clk_oe_r, ps2_dat_oe_r, tx_busy_r, tx_done_r, tx_err_r;

  // Two-flop synchronizers; idle bus level is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 2'b11;
      sync2_r <= 2'b11;
    end else begin
      sync1_r <= {ps2_dat_in, ps2_clk_in};
      sync2_r <= sync1_r;
    end
  end

  // Stability filter: a line changes only after FILTER_CYCLES differing samples in a row.
  always_comb begin
    filt_s = filt_r;
    fcnt_s = fcnt_r;
    for (int i = 0; i < 2; i++) begin
      if (sync2_r[i] == filt_r[i]) begin
        fcnt_s[i] = FLT_ZERO;
      end else if (fcnt_r[i] == FLT_LAST) begin
        filt_s[i] = sync2_r[i];
        fcnt_s[i] = FLT_ZERO;
      end else begin
        fcnt_s[i] = fcnt_r[i] + FLT_ONE;
      end
    end
  end

  // Filter state and the previous filtered clock for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r     <= 2'b11;
      fcnt_r     <= {2{FLT_ZERO}};
      clk_prev_r <= 1'b1;
    end else begin
      filt_r     <= filt_s;
      fcnt_r     <= fcnt_s;
      clk_prev_r <= filt_r[0];
    end
  end

  assign fall_s    = clk_prev_r & ~filt_r[0];
  assign timeout_s = (cnt_r == TO_LAST);

  // Next-state logic: frame shifting, inhibit timing and device-edge watchdog.
  always_comb begin
    state_s  = state_r;
    frame_s  = frame_r;
    bitcnt_s = bitcnt_r;
    cnt_s    = cnt_r;
    done_s   = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // The pulse cycle still reports busy, so a start there is ignored too.
        if (tx_start && !tx_busy_r) begin
          frame_s  = {1'b1, odd_parity(tx_data), tx_data};
          cnt_s    = CNT_ZERO;
          bitcnt_s = 4'd0;
          state_s  = ST_INHIBIT;
        end else begin
          cnt_s    = CNT_ZERO;
          bitcnt_s = 4'd0;
        end
      end
      ST_INHIBIT: begin
        // Device clock activity is deliberately ignored while the host inhibits.
        if (cnt_r == INH_LAST) begin
          cnt_s   = CNT_ZERO;
          state_s = ST_REQ;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_REQ: begin
        if (fall_s) begin
          cnt_s    = CNT_ZERO;
          bitcnt_s = 4'd1;
          state_s  = ST_SHIFT;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_SHIFT: begin
        if (fall_s) begin
          cnt_s    = CNT_ZERO;
          frame_s  = {1'b0, frame_r[9:1]};
          bitcnt_s = bitcnt_r + 4'd1;
          // The stop bit is a released line, so ACK simply leaves dat undriven.
          if (bitcnt_r == 4'd9) begin
            state_s = ST_ACK;
          end else begin
            state_s = ST_SHIFT;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_ACK: begin
        if (fall_s) begin
          cnt_s = CNT_ZERO;
          if (!filt_r[1]) begin
            state_s = ST_WAIT_IDLE;
          end else begin
            err_s   = 1'b1;
            state_s = ST_IDLE;
          end
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_WAIT_IDLE: begin
        if (filt_r[0] && filt_r[1]) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else if (fall_s) begin
          cnt_s = CNT_ZERO;
        end else if (timeout_s) begin
          err_s   = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      frame_r  <= 10'd0;
      bitcnt_r <= 4'd0;
      cnt_r    <= CNT_ZERO;
    end else begin
      state_r  <= state_s;
      frame_r  <= frame_s;
      bitcnt_r <= bitcnt_s;
      cnt_r    <= cnt_s;
    end
  end

  // Registered outputs decoded from the next state; busy also covers the pulse cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps2_clk_oe_r <= 1'b0;
      ps2_dat_oe_r <= 1'b0;
      tx_busy_r    <= 1'b0;
      tx_done_r    <= 1'b0;
      tx_err_r     <= 1'b0;
    end else begin
      ps2_clk_oe_r <= (state_s == ST_INHIBIT);
      ps2_dat_oe_r <= (state_s == ST_REQ) || ((state_s == ST_SHIFT) && !frame_s[0]);
      tx_busy_r    <= (state_s != ST_IDLE) || done_s || err_s;
      tx_done_r    <= done_s;
      tx_err_r     <= err_s;
    end
  end

  assign ps2_clk_oe = ps2_clk_oe_r;
  assign ps2_dat_oe = ps2_dat_oe_r;
  assign tx_busy    = tx_busy_r;
  assign tx_done    = tx_done_r;
  assign tx_err     = tx_err_r;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: a PS/2 device model clocks the frame out of the DUT and
// records the bits it sees; a transaction-level model predicts busy, inhibit
// and request timing cycle by cycle.
module tb_ps2_tx;

  localparam int INH  = 20;
  localparam int TO   = 4000;
  localparam int FLT  = 2;
  localparam int HALF = 300;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       clk_dev  = 1'b1;
  logic       dat_dev  = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_err    = 0;
  int last_err_cyc  = 0;
  int last_fall_cyc = 0;

  // Transaction model state
  bit m_busy = 1'b0;
  int m_cyc  = 0;
  bit m_end  = 1'b0;
  int m_frame_id   = 0;
  int last_pulse_id = -1;

  // Open-drain wiring: a line is low if either side pulls it.
  assign ps2_clk_in = clk_dev & ~ps2_clk_oe;
  assign ps2_dat_in = dat_dev & ~ps2_dat_oe;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO),
    .FILTER_CYCLES (FLT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // The frame a device must see: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Transaction model: a start is accepted only when not busy; busy ends the
  // cycle after the completion pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
    end else if (m_end) begin
      m_busy <= 1'b0;
    end else if (!m_busy && tx_start) begin
      m_busy     <= 1'b1;
      m_cyc      <= 0;
      m_frame_id <= m_frame_id + 1;
    end else if (m_busy) begin
      m_cyc <= m_cyc + 1;
    end
  end

  // Per-cycle comparison against the transaction model.
  always @(negedge clk) begin
    if (!rst) begin
      check("clk_oe", 32'(ps2_clk_oe), 32'(m_busy && (m_cyc < INH)));
      check("busy", 32'(tx_busy), 32'(m_busy));
      if (!m_busy || (m_cyc < INH)) begin
        check("dat_oe_quiet", 32'(ps2_dat_oe), 32'd0);
      end else if (m_cyc == INH) begin
        check("dat_oe_req", 32'(ps2_dat_oe), 32'd1);
      end
      check("done_err_excl", 32'(tx_done && tx_err), 32'd0);
      if (tx_done || tx_err) begin
        check("pulse_in_busy", 32'(tx_busy), 32'd1);
        check("one_pulse_per_frame", 32'(last_pulse_id == m_frame_id), 32'd0);
        last_pulse_id <= m_frame_id;
      end
      if (tx_done) n_done <= n_done + 1;
      if (tx_err) begin
        n_err        <= n_err + 1;
        last_err_cyc <= cyc;
      end
      m_end <= tx_done || tx_err;
    end else begin
      m_end <= 1'b0;
    end
  end

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    cycles(1);
    tx_start = 1'b0;
  endtask

  // Device model: waits for the request, then issues nfall clocks, sampling
  // dat at the end of each high phase. Optionally pulses tx_start mid-frame.
  task automatic dev_frame(input int nfall, input bit ack, input int inject, output logic [10:0] got);
    int w;
    got = 11'd0;
    w   = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && (w < 200)) begin
      cycles(1);
      w++;
    end
    check("req_seen", 32'(w < 200), 32'd1);
    cycles(HALF);
    for (int i = 0; i < nfall; i++) begin
      got[i] = ps2_dat_in;
      if (i == inject) begin
        tx_data  = 8'h55;
        tx_start = 1'b1;
        cycles(1);
        tx_start = 1'b0;
      end
      if ((i == 10) && ack) begin
        dat_dev = 1'b0;
        cycles(50);
      end
      clk_dev = 1'b0;
      last_fall_cyc = cyc;
      cycles(HALF);
      clk_dev = 1'b1;
      cycles(HALF);
    end
    dat_dev = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit ack, input int inject,
                           output logic [10:0] got, output int dd, output int de);
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    check("idle_before", 32'(tx_busy), 32'd0);
    send(d);
    dev_frame(11, ack, inject, got);
    cycles(30);
    dd = n_done - d0;
    de = n_err - e0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] got;
    logic [7:0]  rd;
    bit          rack;
    int dd, de, e0, w, delta;

    rst = 1'b1;
    cycles(5);
    check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    rst = 1'b0;
    cycles(5);

    // 1: 0xED with ACK
    run_frame(8'hED, 1'b1, -1, got, dd, de);
    check("t1_bits", 32'(got), 32'(11'b11111011010));
    check("t1_done", 32'(dd), 32'd1);
    check("t1_err", 32'(de), 32'd0);
    check("t1_oe_after", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

    // 2: 0x01 -> parity 0
    run_frame(8'h01, 1'b1, -1, got, dd, de);
    check("t2_parity", 32'(got[9]), 32'd0);
    check("t2_bits", 32'(got), 32'(exp_frame(8'h01)));
    check("t2_done", 32'(dd), 32'd1);

    // 3: no ACK
    run_frame(8'hA7, 1'b0, -1, got, dd, de);
    check("t3_bits", 32'(got), 32'(exp_frame(8'hA7)));
    check("t3_err", 32'(de), 32'd1);
    check("t3_done", 32'(dd), 32'd0);
    check("t3_oe_after", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

    // 4: device stops after 4 clocks -> timeout
    e0 = n_err;
    send(8'h3C);
    dev_frame(4, 1'b0, -1, got);
    check("t4_bits", 32'(got[3:0]), 32'(exp_frame(8'h3C) & 11'h00F));
    w = 0;
    while ((n_err == e0) && (w < 5000)) begin
      cycles(1);
      w++;
    end
    check("t4_timeout_seen", 32'(w < 5000), 32'd1);
    delta = last_err_cyc - last_fall_cyc;
    check("t4_timeout_delay", 32'((delta >= TO) && (delta <= TO + 10)), 32'd1);
    check("t4_busy_cleared", 32'(tx_busy), 32'd0);
    check("t4_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    check("t4_done", 32'(n_done), 32'd2);

    // 5: mid-frame start is ignored
    run_frame(8'hED, 1'b1, 3, got, dd, de);
    check("t5_bits", 32'(got), 32'(11'b11111011010));
    check("t5_done", 32'(dd), 32'd1);
    check("t5_err", 32'(de), 32'd0);

    // 6: reset during SHIFT
    send(8'hED);
    dev_frame(5, 1'b0, -1, got);
    check("t6_busy_pre", 32'(tx_busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
    check("t6_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
    check("t6_rst_busy", 32'(tx_busy), 32'd0);
    cycles(3);
    rst = 1'b0;
    cycles(10);
    run_frame(8'hFF, 1'b1, -1, got, dd, de);
    check("t6_bits", 32'(got), 32'(11'b11111111110));
    check("t6_parity", 32'(got[9]), 32'd1);
    check("t6_done", 32'(dd), 32'd1);

    // Random frames
    for (int k = 0; k < 3; k++) begin
      rd   = 8'($urandom_range(0, 255));
      rack = ($urandom_range(0, 3) != 0);
      run_frame(rd, rack, -1, got, dd, de);
      check("rnd_bits", 32'(got), 32'(exp_frame(rd)));
      check("rnd_done", 32'(dd), 32'(rack));
      check("rnd_err", 32'(de), 32'(!rack));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
